// File: rtl/rv16_pkg.sv
// Shared defaults and width helpers for the rv16 register file slice.
package rv16_pkg;

  localparam int unsigned NREGS_DEFAULT = 16;
  localparam int unsigned XLEN_DEFAULT  = 16;

  function automatic int unsigned addr_width(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback, issue and debug signals of the scoreboarded register file.
interface regfile_sb_if
  import rv16_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
);
  localparam int unsigned AW = addr_width(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_stall;
  logic [AW:0]         busy_cnt;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, dbg_addr,
    input  rd_data, rd_busy, iss_stall, busy_cnt, dbg_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, dbg_addr,
    output rd_data, rd_busy, iss_stall, busy_cnt, dbg_data
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservation on issue, release on writeback, WAW stall.
module regfile_scoreboard
  import rv16_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  parameter int unsigned AW    = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic              iss_stall,
  output logic [NRD-1:0]    rd_busy,
  output logic [AW:0]       busy_cnt
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] set;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      cnt_next;

  always_comb begin
    clr = '0;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
        clr[wr_addr[w*AW +: AW]] = 1'b1;
    end

    // A writeback landing this cycle releases the register, so it does not stall.
    iss_stall = iss_valid && (iss_rd != '0) && busy[iss_rd] && !clr[iss_rd];

    set = '0;
    if (iss_valid && (iss_rd != '0) && !iss_stall)
      set[iss_rd] = 1'b1;

    busy_next = (busy & ~clr) | set;

    cnt_next = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};

    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_busy[k] = (rd_addr[k*AW +: AW] != '0) && busy[rd_addr[k*AW +: AW]]
                   && !clr[rd_addr[k*AW +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with writeback bypass, R0 hardwired to zero and a busy scoreboard.
module regfile_sb
  import rv16_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   bus
);

  localparam int unsigned AW = addr_width(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  // Ports are visited in ascending order, so the highest-numbered port wins a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != '0)
          regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (bus.rd_addr[k*AW +: AW] != '0) begin
        bus.rd_data[k*XLEN +: XLEN] = regs[bus.rd_addr[k*AW +: AW]];
        for (int unsigned w = 0; w < NWR; w++) begin
          if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == bus.rd_addr[k*AW +: AW])
            bus.rd_data[k*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .rd_addr   (bus.rd_addr),
    .iss_stall (bus.iss_stall),
    .rd_busy   (bus.rd_busy),
    .busy_cnt  (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Vector-table bench for regfile_sb (16 regs, 16 bits, 2 read ports, 2 write ports).
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_sb_if #(.NREGS(16), .XLEN(16), .NRD(2), .NWR(2)) bus ();

  regfile_sb #(.NREGS(16), .XLEN(16), .NRD(2), .NWR(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        chk;
    bit        r;
    bit [1:0]  we;
    bit [3:0]  wa0;
    bit [15:0] wd0;
    bit [3:0]  wa1;
    bit [15:0] wd1;
    bit        iv;
    bit [3:0]  ird;
    bit [3:0]  ra0;
    bit [3:0]  ra1;
    bit [3:0]  da;
    bit [15:0] e_rd0;
    bit [15:0] e_rd1;
    bit [1:0]  e_rb;
    bit        e_st;
    bit [4:0]  e_cnt;
    bit [15:0] e_dd;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   errors = 0;

  function automatic vec_t mk(bit chk, bit r, bit [1:0] we, bit [3:0] wa0, bit [15:0] wd0,
                              bit [3:0] wa1, bit [15:0] wd1, bit iv, bit [3:0] ird,
                              bit [3:0] ra0, bit [3:0] ra1, bit [3:0] da,
                              bit [15:0] e_rd0, bit [15:0] e_rd1, bit [1:0] e_rb,
                              bit e_st, bit [4:0] e_cnt, bit [15:0] e_dd);
    vec_t v;
    v.chk = chk; v.r = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ird = ird; v.ra0 = ra0; v.ra1 = ra1; v.da = da;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb = e_rb; v.e_st = e_st; v.e_cnt = e_cnt;
    v.e_dd = e_dd;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL v%0d %s got=0x%0h exp=0x%0h", idx, nm, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, errors + 1);
  end

  initial begin
    vec_t v;
    vec_t e;
    rst = 1'b1;
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.rd_addr = '0; bus.dbg_addr = '0;

    //          chk r  we     wa0 wd0      wa1 wd1      iv ird ra0 ra1 da | rd0      rd1      rb     st cnt dd
    vecs.push_back(mk(0, 1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000));
    // traffic during reset is bypassed combinationally but must not stick
    vecs.push_back(mk(1, 1, 2'b01, 3, 16'h9999, 0, 16'h0000, 1, 6, 3, 6, 3, 16'h9999, 16'h0000, 2'b00, 0, 0, 16'h0000));
    for (int a = 0; a < 16; a++)
      vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 4'(a), 4'(15 - a), 4'(a),
                        16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000));
    // reserve R3, observe busy, release with bypassed writeback
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 3, 3, 0, 3, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 3, 3, 0, 16'h0000, 16'h0000, 2'b11, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b01, 3, 16'h1234, 0, 16'h0000, 0, 0, 3, 3, 3, 16'h1234, 16'h1234, 2'b00, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 3, 0, 3, 16'h1234, 16'h0000, 2'b00, 0, 0, 16'h1234));
    // WAW stall on R5, then same request alongside a writeback to R5
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 5, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 5, 5, 0, 0, 16'h0000, 16'h0000, 2'b01, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b01, 5, 16'h0BEE, 0, 16'h0000, 1, 5, 5, 5, 0, 16'h0BEE, 16'h0BEE, 2'b00, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 5, 0, 5, 16'h0BEE, 16'h0000, 2'b01, 0, 1, 16'h0BEE));
    vecs.push_back(mk(1, 0, 2'b01, 5, 16'h0C0C, 0, 16'h0000, 0, 0, 5, 0, 0, 16'h0C0C, 16'h0000, 2'b00, 0, 1, 16'h0000));
    // both write ports on R7: port 1 wins
    vecs.push_back(mk(1, 0, 2'b11, 7, 16'hAAAA, 7, 16'h5555, 0, 0, 7, 7, 7, 16'h5555, 16'h5555, 2'b00, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 7, 0, 7, 16'h5555, 16'h0000, 2'b00, 0, 0, 16'h5555));
    // R0 write and issue are ignored while R9 is reserved
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 9, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b01, 0, 16'hFFFF, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 9, 0, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0000));
    // reserve R2, R4, then reset mid-operation drops everything
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 2, 2, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 4, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 2, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 2, 4, 0, 16'h0000, 16'h0000, 2'b11, 0, 3, 16'h0000));
    vecs.push_back(mk(1, 1, 2'b01, 4, 16'h7777, 0, 16'h0000, 1, 6, 4, 2, 4, 16'h7777, 16'h0000, 2'b10, 0, 3, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b01, 2, 16'h0042, 0, 16'h0000, 0, 0, 2, 4, 6, 16'h0042, 16'h0000, 2'b00, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 2, 6, 2, 16'h0042, 16'h0000, 2'b00, 0, 0, 16'h0042));
    // release through write port 1
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 1, 10, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b10, 0, 16'h0000, 10, 16'h00A5, 0, 0, 0, 10, 0, 16'h0000, 16'h00A5, 2'b00, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 0, 10, 0, 10, 16'h00A5, 16'h0000, 2'b00, 0, 0, 16'h00A5));

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      rst           = v.r;
      bus.wr_en     = v.we;
      bus.wr_addr   = {v.wa1, v.wa0};
      bus.wr_data   = {v.wd1, v.wd0};
      bus.iss_valid = v.iv;
      bus.iss_rd    = v.ird;
      bus.rd_addr   = {v.ra1, v.ra0};
      bus.dbg_addr  = v.da;
      exp_q.push_back(v);
      #2;
      e = exp_q.pop_front();
      if (e.chk) begin
        check("rd_data0", i, 32'(bus.rd_data[15:0]), 32'(e.e_rd0));
        check("rd_data1", i, 32'(bus.rd_data[31:16]), 32'(e.e_rd1));
        check("rd_busy", i, 32'(bus.rd_busy), 32'(e.e_rb));
        check("iss_stall", i, 32'(bus.iss_stall), 32'(e.e_st));
        check("busy_cnt", i, 32'(bus.busy_cnt), 32'(e.e_cnt));
        check("dbg_data", i, 32'(bus.dbg_data), 32'(e.e_dd));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
